// File: rtl/seq_frame_sync_ctrl.sv
`timescale 1ns/1ps
// ============================================================================
// seq_frame_sync_ctrl
// ----------------------------------------------------------------------------
// Frame-synchronisation controller sitting between an error-tolerant
// shift-register pattern detector and a downstream deframer.
//
// It programs the detector (pattern + allowed bit errors), flushes the
// detector after every reconfiguration, hunts for the sync word, confirms it
// at exact FRAME_LEN spacing, then flywheels through isolated misses while
// locked and drops lock after LOSS_N consecutive on-time misses.
//
// Ports:
//   i_clk          rising-edge clock
//   i_reset        synchronous, active-high reset
//   i_cfg_valid    configuration request
//   o_cfg_ready    configuration accept (low while flushing)
//   i_cfg_pattern  new sync pattern
//   i_cfg_tol      new allowed bit errors
//   i_bit_valid    detector consumes a stream bit this cycle
//   i_match        detector match on this valid bit
//   o_cfg_pattern  registered pattern driven to the detector
//   o_cfg_tol      registered tolerance driven to the detector
//   o_det_clear    one-cycle detector shift-register clear
//   o_state        0=HUNT 1=VERIFY 2=LOCKED 3=FLUSH
//   o_locked       high while LOCKED
//   o_frame_start  frame-start strobe, high up to and including the valid
//                  bit that carries o_bit_pos=0
//   o_bit_pos      position within the frame (0 = first bit after sync)
//   o_lock_lost    one-cycle pulse when lock is dropped
// ============================================================================
module seq_frame_sync_ctrl #(
    parameter  int PAT_LEN   = 12,
    parameter  int FRAME_LEN = 24,
    parameter  int CONFIRM_N = 2,
    parameter  int LOSS_N    = 3,
    parameter  int TOL_W     = 2,
    localparam int POS_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [PAT_LEN-1:0] i_cfg_pattern,
    input  logic [TOL_W-1:0]   i_cfg_tol,
    input  logic               i_bit_valid,
    input  logic               i_match,
    output logic [PAT_LEN-1:0] o_cfg_pattern,
    output logic [TOL_W-1:0]   o_cfg_tol,
    output logic               o_det_clear,
    output logic [1:0]         o_state,
    output logic               o_locked,
    output logic               o_frame_start,
    output logic [POS_W-1:0]   o_bit_pos,
    output logic               o_lock_lost
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam int CONF_W = $clog2(CONFIRM_N + 1);
    localparam int MISS_W = $clog2(LOSS_N + 1);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(FRAME_LEN - 1);
    localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_N - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_N - 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    state_t              r_state;
    logic [FILL_W-1:0]   r_fill;
    logic [POS_W-1:0]    r_bit_pos;
    logic [CONF_W-1:0]   r_confirm;
    logic [MISS_W-1:0]   r_miss;
    logic [PAT_LEN-1:0]  r_pattern;
    logic [TOL_W-1:0]    r_tol;
    logic                r_det_clear;
    logic                r_frame_start;
    logic                r_lock_lost;

    // Config is refused only while flushing, so a reprogram cannot restart
    // the flush it is waiting on.
    logic w_cfg_fire;
    logic w_on_time;

    assign w_cfg_fire = i_cfg_valid && (r_state != ST_FLUSH);
    // Only the last position of the frame carries a sync verdict.
    assign w_on_time  = (r_bit_pos == POS_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_FLUSH;
            r_fill        <= '0;
            r_bit_pos     <= '0;
            r_confirm     <= '0;
            r_miss        <= '0;
            r_pattern     <= '1;
            r_tol         <= '0;
            r_det_clear   <= 1'b1;
            r_frame_start <= 1'b0;
            r_lock_lost   <= 1'b0;
        end else begin
            r_det_clear <= 1'b0;
            r_lock_lost <= 1'b0;

            if (w_cfg_fire) begin
                // Reconfiguration beats any simultaneous on-time slot.
                r_pattern     <= i_cfg_pattern;
                r_tol         <= i_cfg_tol;
                r_det_clear   <= 1'b1;
                r_lock_lost   <= (r_state == ST_LOCKED);
                r_state       <= ST_FLUSH;
                r_fill        <= '0;
                r_bit_pos     <= '0;
                r_confirm     <= '0;
                r_miss        <= '0;
                r_frame_start <= 1'b0;
            end else if (i_bit_valid) begin
                // The strobe is consumed by this valid bit; a new sync
                // verdict below may re-arm it for the next one.
                r_frame_start <= 1'b0;

                case (r_state)
                    ST_FLUSH: begin
                        // Matches are meaningless until the detector holds
                        // PAT_LEN genuine stream bits.
                        if (r_fill == FILL_LAST) begin
                            r_fill  <= '0;
                            r_state <= ST_HUNT;
                        end else begin
                            r_fill <= r_fill + FILL_W'(1);
                        end
                    end

                    ST_HUNT: begin
                        if (i_match) begin
                            r_state       <= ST_VERIFY;
                            r_bit_pos     <= '0;
                            r_confirm     <= CONF_W'(1);
                            r_frame_start <= 1'b1;
                        end
                    end

                    ST_VERIFY: begin
                        if (w_on_time) begin
                            r_bit_pos <= '0;
                            if (i_match) begin
                                r_frame_start <= 1'b1;
                                if (r_confirm == CONF_LAST) begin
                                    r_state   <= ST_LOCKED;
                                    r_confirm <= '0;
                                    r_miss    <= '0;
                                end else begin
                                    r_confirm <= r_confirm + CONF_W'(1);
                                end
                            end else begin
                                r_state   <= ST_HUNT;
                                r_confirm <= '0;
                            end
                        end else begin
                            r_bit_pos <= r_bit_pos + POS_W'(1);
                        end
                    end

                    ST_LOCKED: begin
                        if (w_on_time) begin
                            r_bit_pos <= '0;
                            if (i_match) begin
                                r_miss        <= '0;
                                r_frame_start <= 1'b1;
                            end else if (r_miss == MISS_LAST) begin
                                r_state     <= ST_HUNT;
                                r_miss      <= '0;
                                r_lock_lost <= 1'b1;
                            end else begin
                                // Flywheel: keep framing through an
                                // isolated missed sync word.
                                r_miss        <= r_miss + MISS_W'(1);
                                r_frame_start <= 1'b1;
                            end
                        end else begin
                            r_bit_pos <= r_bit_pos + POS_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign o_cfg_ready   = (r_state != ST_FLUSH);
    assign o_cfg_pattern = r_pattern;
    assign o_cfg_tol     = r_tol;
    assign o_det_clear   = r_det_clear;
    assign o_state       = r_state;
    assign o_locked      = (r_state == ST_LOCKED);
    assign o_frame_start = r_frame_start;
    assign o_bit_pos     = r_bit_pos;
    assign o_lock_lost   = r_lock_lost;

endmodule

// File: tb/tb_seq_frame_sync_ctrl.sv
`timescale 1ns/1ps
// ============================================================================
// tb_seq_frame_sync_ctrl
// ----------------------------------------------------------------------------
// Randomised stream of sync words and payload bits; i_match comes from a
// behavioural detector model (Hamming distance against the programmed
// pattern). A reference model, written as counts of valid bits since the last
// accepted sync, predicts every output after each clock edge.
// ============================================================================
module tb_seq_frame_sync_ctrl;

    localparam int PAT_LEN   = 12;
    localparam int FRAME_LEN = 24;
    localparam int CONFIRM_N = 2;
    localparam int LOSS_N    = 3;
    localparam int TOL_W     = 2;
    localparam int POS_W     = $clog2(FRAME_LEN);

    localparam logic [11:0] SYNC     = 12'hE2B;
    localparam logic [11:0] SYNC_BAD = 12'hE2B ^ 12'h111;  // 3 bit errors

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic               i_cfg_valid;
    logic               o_cfg_ready;
    logic [PAT_LEN-1:0] i_cfg_pattern;
    logic [TOL_W-1:0]   i_cfg_tol;
    logic               i_bit_valid;
    logic               i_match;
    logic [PAT_LEN-1:0] o_cfg_pattern;
    logic [TOL_W-1:0]   o_cfg_tol;
    logic               o_det_clear;
    logic [1:0]         o_state;
    logic               o_locked;
    logic               o_frame_start;
    logic [POS_W-1:0]   o_bit_pos;
    logic               o_lock_lost;

    seq_frame_sync_ctrl #(
        .PAT_LEN   (PAT_LEN),
        .FRAME_LEN (FRAME_LEN),
        .CONFIRM_N (CONFIRM_N),
        .LOSS_N    (LOSS_N),
        .TOL_W     (TOL_W)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_cfg_valid   (i_cfg_valid),
        .o_cfg_ready   (o_cfg_ready),
        .i_cfg_pattern (i_cfg_pattern),
        .i_cfg_tol     (i_cfg_tol),
        .i_bit_valid   (i_bit_valid),
        .i_match       (i_match),
        .o_cfg_pattern (o_cfg_pattern),
        .o_cfg_tol     (o_cfg_tol),
        .o_det_clear   (o_det_clear),
        .o_state       (o_state),
        .o_locked      (o_locked),
        .o_frame_start (o_frame_start),
        .o_bit_pos     (o_bit_pos),
        .o_lock_lost   (o_lock_lost)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0=HUNT 1=VERIFY 2=LOCKED 3=FLUSH.
    int          m_state, m_fill, m_since, m_syncs, m_miss;
    logic        m_fs, m_ll, m_dc;
    logic [11:0] m_pat;
    logic [1:0]  m_tol;

    // Detector model (stimulus side) and lock-timing monitor.
    logic [11:0] det_sh = '0;
    bit          gaps_en = 1'b0;
    int          vidx = 0, verify_at = 0, prev_state = 3;

    task automatic model_step(input logic rst, input logic v, input logic m,
                              input logic cv, input logic [11:0] cp, input logic [1:0] ct);
        logic fs_next;
        if (rst) begin
            m_state = 3; m_fill = 0; m_since = 0; m_syncs = 0; m_miss = 0;
            m_fs = 1'b0; m_ll = 1'b0; m_dc = 1'b1; m_pat = '1; m_tol = '0;
            return;
        end
        m_dc = 1'b0;
        m_ll = 1'b0;
        if (cv && m_state != 3) begin
            m_ll = (m_state == 2);
            m_state = 3; m_pat = cp; m_tol = ct; m_dc = 1'b1;
            m_fill = 0; m_since = 0; m_syncs = 0; m_miss = 0; m_fs = 1'b0;
        end else if (v) begin
            fs_next = 1'b0;
            case (m_state)
                3: begin
                    m_fill++;
                    if (m_fill == PAT_LEN) begin m_fill = 0; m_state = 0; end
                end
                0: if (m) begin m_state = 1; m_since = 0; m_syncs = 1; fs_next = 1'b1; end
                default: begin
                    if (m_since == FRAME_LEN - 1) begin
                        m_since = 0;
                        if (m) begin
                            fs_next = 1'b1; m_miss = 0; m_syncs++;
                            if (m_state == 1 && m_syncs >= CONFIRM_N) m_state = 2;
                        end else if (m_state == 1) begin
                            m_state = 0; m_syncs = 0;
                        end else begin
                            m_miss++;
                            if (m_miss >= LOSS_N) begin
                                m_state = 0; m_ll = 1'b1; m_miss = 0; m_syncs = 0;
                            end else begin
                                fs_next = 1'b1;
                            end
                        end
                    end else begin
                        m_since++;
                    end
                end
            endcase
            m_fs = fs_next;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare at +1.
    task automatic cycle(input logic rst, input logic v, input logic b,
                         input logic fe, input logic fv,
                         input logic cv, input logic [11:0] cp, input logic [1:0] ct);
        logic m;
        logic acc;
        m = 1'($urandom_range(0, 1));  // must be ignored on idle cycles
        if (v) begin
            det_sh = {det_sh[10:0], b};
            m = ($countones(det_sh ^ m_pat) <= int'(m_tol));
        end
        if (fe) m = fv;
        acc = !rst && cv && (m_state != 3);
        i_reset = rst; i_bit_valid = v; i_match = m;
        i_cfg_valid = cv; i_cfg_pattern = cp; i_cfg_tol = ct;
        @(posedge i_clk);
        model_step(rst, v, m, cv, cp, ct);
        if (acc) det_sh = '0;
        if (!rst && v) vidx++;
        #1;
        check("state",       int'(o_state),       m_state);
        check("bit_pos",     int'(o_bit_pos),     m_since);
        check("frame_start", int'(o_frame_start), int'(m_fs));
        check("lock_lost",   int'(o_lock_lost),   int'(m_ll));
        check("det_clear",   int'(o_det_clear),   int'(m_dc));
        check("cfg_ready",   int'(o_cfg_ready),   int'(m_state != 3));
        check("locked",      int'(o_locked),      int'(m_state == 2));
        check("cfg_pattern", int'(o_cfg_pattern), int'(m_pat));
        check("cfg_tol",     int'(o_cfg_tol),     int'(m_tol));
        if (o_state == 2'd1 && prev_state != 1) verify_at = vidx;
        if (o_state == 2'd2 && prev_state == 1) check("lock_dist", vidx - verify_at, FRAME_LEN);
        prev_state = int'(o_state);
    endtask

    task automatic send_bit(input logic b, input logic fe = 1'b0, input logic fv = 1'b0);
        if (gaps_en && $urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 4)) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'd0);
        end
        cycle(1'b0, 1'b1, b, fe, fv, 1'b0, 12'h000, 2'd0);
    endtask

    task automatic send_word(input logic [11:0] w);
        for (int i = 11; i >= 0; i--) send_bit(w[i]);
    endtask

    // True when payload pl followed by the next sync word produces no
    // detector match before the final sync bit.
    function automatic bit clean_payload(input logic [11:0] sh0, input logic [11:0] pl,
                                         input logic [11:0] pat, input int tol);
        logic [11:0] sh;
        logic [22:0] seq;
        sh  = sh0;
        seq = {pl, pat[11:1]};
        for (int i = 22; i >= 0; i--) begin
            sh = {sh[10:0], seq[i]};
            if ($countones(sh ^ pat) <= tol) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [11:0] pick_payload();
        logic [11:0] pl;
        pl = 12'($urandom);
        for (int t = 0; t < 200; t++) begin
            if (clean_payload(det_sh, pl, m_pat, int'(m_tol))) break;
            pl = 12'($urandom);
        end
        return pl;
    endfunction

    task automatic send_payload();
        send_word(pick_payload());
    endtask

    initial begin
        logic [11:0] pl;
        i_reset = 1'b1; i_cfg_valid = 1'b0; i_cfg_pattern = '0; i_cfg_tol = '0;
        i_bit_valid = 1'b0; i_match = 1'b0;

        // Reset and the initial flush.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123, 2'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'd0);
        check("rst_det_clear", int'(o_det_clear), 1);
        check("rst_pattern", int'(o_cfg_pattern), 'hFFF);
        for (int i = 0; i < PAT_LEN; i++) begin
            cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 12'h000, 2'd0);
            if (i == 0) check("det_clear_once", int'(o_det_clear), 0);
            if (i == PAT_LEN - 2) check("flush_hold", int'(o_state), 3);
        end
        check("flush_done", int'(o_state), 0);

        // Program E2B / tol 2, flush, then acquire.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SYNC, 2'd2);
        check("cfg_flush", int'(o_state), 3);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'd0);
        send_payload();
        send_word(SYNC);
        check("verify_entry", int'(o_state), 1);
        send_payload();
        send_word(SYNC);
        check("lock_entry", int'(o_locked), 1);
        for (int f = 0; f < 2; f++) begin
            send_payload();
            send_word(SYNC);
        end

        // Single miss is flywheeled, then three in a row drop lock.
        send_payload();
        send_word(SYNC_BAD);
        check("miss1_locked", int'(o_locked), 1);
        check("miss1_fs", int'(o_frame_start), 1);
        send_payload();
        send_word(SYNC);
        check("recover_locked", int'(o_locked), 1);
        for (int k = 0; k < LOSS_N; k++) begin
            send_payload();
            send_word(SYNC_BAD);
            if (k == LOSS_N - 1) begin
                check("loss_pulse", int'(o_lock_lost), 1);
                check("loss_hunt", int'(o_state), 0);
            end
        end

        // VERIFY ignores an off-slot match and falls back on an on-time miss.
        send_payload();
        send_word(SYNC);
        check("verify_again", int'(o_state), 1);
        pl = pick_payload();
        for (int i = 11; i >= 0; i--) begin
            send_bit(pl[i], (i == 6), 1'b1);  // 6th payload bit sits at bit_pos 5
            if (i == 6) check("offslot_ignored", int'(o_state), 1);
        end
        for (int i = 11; i >= 0; i--) send_bit(SYNC[i], (i == 0), 1'b0);
        check("verify_miss", int'(o_state), 0);
        check("verify_no_loss", int'(o_lock_lost), 0);

        // Idle gaps must not change valid-bit timing.
        gaps_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            send_payload();
            send_word(SYNC);
        end
        check("gap_locked", int'(o_locked), 1);

        // Config on the on-time slot while locked.
        send_payload();
        for (int i = 11; i >= 1; i--) send_bit(SYNC[i]);
        cycle(1'b0, 1'b1, SYNC[0], 1'b0, 1'b0, 1'b1, 12'h5A3, 2'd1);
        check("slot_cfg_lost", int'(o_lock_lost), 1);
        check("slot_cfg_state", int'(o_state), 3);
        check("slot_cfg_pat", int'(o_cfg_pattern), 'h5A3);
        check("slot_cfg_clear", int'(o_det_clear), 1);
        for (int i = 0; i < PAT_LEN; i++) begin
            if (gaps_en && $urandom_range(0, 1) == 1)
                cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0F0, 2'd3);
            cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, 12'h0F0, 2'd3);
            if (i < PAT_LEN - 1) check("flush_not_ready", int'(o_cfg_ready), 0);
        end
        check("flush_ready", int'(o_cfg_ready), 1);
        check("flush_kept_pat", int'(o_cfg_pattern), 'h5A3);
        gaps_en = 1'b0;

        // Reset overrides a pending config request.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123, 2'd1);
        check("midrst_pat", int'(o_cfg_pattern), 'hFFF);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
